// File: rtl/tt_seq_pkg.sv
// rtl/tt_seq_pkg.sv - shared opcodes, FSM states and pin-bus bit positions for tt_pin_sequencer
package tt_seq_pkg;

    localparam logic [2:0] OP_SET_UI    = 3'd0;
    localparam logic [2:0] OP_SET_UIO   = 3'd1;
    localparam logic [2:0] OP_SET_CTRL  = 3'd2;
    localparam logic [2:0] OP_CLOCK_N   = 3'd3;
    localparam logic [2:0] OP_SAMPLE    = 3'd4;
    localparam logic [2:0] OP_GET_COUNT = 3'd5;
    localparam logic [2:0] OP_NOP6      = 3'd6;
    localparam logic [2:0] OP_NOP7      = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        CLK_HI,
        CLK_LO,
        RSP_WAIT
    } seq_state_t;

    localparam int IW_CLK     = 0;
    localparam int IW_RSTN    = 1;
    localparam int IW_UI_LSB  = 2;
    localparam int IW_UIO_LSB = 10;
    localparam int OW_UO_LSB  = 0;
    localparam int OW_UIO_LSB = 8;
    localparam int OW_OE_LSB  = 16;

endpackage

// File: rtl/tt_seq_clkgen.sv
// rtl/tt_seq_clkgen.sv - project clock generator: phase/period counters, pclk level and end-of-run detect
module tt_seq_clkgen #(
    parameter int HALF_PERIOD = 2,
    parameter int HP_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] n,
    output logic       pclk,
    output logic       phase_end,
    output logic       done
);

    logic [HP_W-1:0] hp_cnt;
    logic [8:0]      remaining;
    logic            last_period;

    assign last_period = (remaining == 9'd1);
    assign phase_end   = (remaining != 9'd0) && (hp_cnt == HP_W'(HALF_PERIOD - 1));
    assign done        = phase_end && !pclk && last_period;

    // remaining counts periods still owed, including the one in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            pclk      <= 1'b0;
            hp_cnt    <= '0;
            remaining <= '0;
        end else if (start) begin
            pclk      <= 1'b1;
            hp_cnt    <= '0;
            remaining <= (n == 8'd0) ? 9'd256 : {1'b0, n};
        end else if (phase_end) begin
            hp_cnt <= '0;
            if (pclk) begin
                pclk <= 1'b0;
            end else begin
                remaining <= remaining - 9'd1;
                pclk      <= !last_period;
            end
        end else if (remaining != 9'd0) begin
            hp_cnt <= hp_cnt + HP_W'(1);
        end
    end

endmodule

// File: rtl/tt_pin_sequencer.sv
// rtl/tt_pin_sequencer.sv - command-driven iw/ow pin sequencer; TT_SEQ_CLK_COUNT_EN adds the rising-edge counter
module tt_pin_sequencer #(
    parameter int HALF_PERIOD = 2,
    parameter int HP_W        = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [7:0]  cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [23:0] rsp_data,
    output logic [17:0] iw,
    output logic        ena,
    input  logic [23:0] ow,
    output logic        busy
);
    import tt_seq_pkg::*;

    seq_state_t  state, state_next;
    logic        accept, start;
    logic [7:0]  ui_q, uio_q;
    logic        rstn_q, ena_q;
    logic [23:0] rsp_q, ow_packed, count_value;
    logic        pclk, phase_end, done;

    assign accept = cmd_valid && (state == IDLE);
    assign start  = accept && (cmd_op == OP_CLOCK_N);

    tt_seq_clkgen #(
        .HALF_PERIOD (HALF_PERIOD),
        .HP_W        (HP_W)
    ) u_clkgen (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n         (cmd_data),
        .pclk      (pclk),
        .phase_end (phase_end),
        .done      (done)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_op == OP_CLOCK_N)
                        state_next = CLK_HI;
                    else if (cmd_op == OP_SAMPLE || cmd_op == OP_GET_COUNT)
                        state_next = RSP_WAIT;
                end
            end
            CLK_HI:   if (phase_end) state_next = CLK_LO;
            CLK_LO:   if (phase_end) state_next = done ? IDLE : CLK_HI;
            RSP_WAIT: if (rsp_ready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    assign ow_packed = {ow[OW_OE_LSB +: 8], ow[OW_UIO_LSB +: 8], ow[OW_UO_LSB +: 8]};

    // commands are only accepted in IDLE, so pin levels cannot move while clocking
    always_ff @(posedge clk) begin
        if (rst) begin
            ui_q   <= '0;
            uio_q  <= '0;
            rstn_q <= 1'b0;
            ena_q  <= 1'b0;
            rsp_q  <= '0;
        end else if (accept) begin
            case (cmd_op)
                OP_SET_UI:    ui_q  <= cmd_data;
                OP_SET_UIO:   uio_q <= cmd_data;
                OP_SET_CTRL: begin
                    rstn_q <= cmd_data[0];
                    ena_q  <= cmd_data[1];
                end
                OP_SAMPLE:    rsp_q <= ow_packed;
                OP_GET_COUNT: rsp_q <= count_value;
                OP_CLOCK_N, OP_NOP6, OP_NOP7: ;
                default: ;
            endcase
        end
    end

`ifdef TT_SEQ_CLK_COUNT_EN
    logic        rise;
    logic [23:0] clk_count;

    assign rise = start || (state == CLK_LO && phase_end && !done);

    always_ff @(posedge clk) begin
        if (rst)
            clk_count <= '0;
        else if (accept && cmd_op == OP_SET_CTRL && !cmd_data[0])
            clk_count <= '0;
        else if (rise)
            clk_count <= clk_count + 24'd1;
    end

    assign count_value = clk_count;
`else
    assign count_value = '0;
`endif

    always_comb begin
        iw                    = '0;
        iw[IW_CLK]            = pclk;
        iw[IW_RSTN]           = rstn_q;
        iw[IW_UI_LSB +: 8]    = ui_q;
        iw[IW_UIO_LSB +: 8]   = uio_q;
    end

    assign ena       = ena_q;
    assign rsp_data  = rsp_q;
    assign rsp_valid = (state == RSP_WAIT);
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_tt_pin_sequencer.sv
// tb/tb_tt_pin_sequencer.sv - randomized self-checking bench for tt_pin_sequencer against a cycle-count model
module tb_tt_pin_sequencer;

    localparam int HP = 2;
`ifdef TT_SEQ_CLK_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk, rst;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_op;
    logic [7:0]  cmd_data;
    logic        rsp_valid, rsp_ready;
    logic [23:0] rsp_data;
    logic [17:0] iw;
    logic        ena;
    logic [23:0] ow;
    logic        busy;

    tt_pin_sequencer #(.HALF_PERIOD(HP), .HP_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .iw        (iw),
        .ena       (ena),
        .ow        (ow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_on = 1'b0;
    bit ow_rand = 1'b0;
    int edges = 0;
    int busy_cnt = 0;
    logic prev_clk = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: a clock run is just "k cycles elapsed out of total"
    int          m_k, m_total;
    logic [7:0]  m_ui, m_uio;
    logic        m_rstn, m_ena, m_pend;
    logic [23:0] m_rsp, m_count;

    always @(posedge clk) begin
        if (rst) begin
            m_k = 0; m_total = 0; m_ui = '0; m_uio = '0;
            m_rstn = 1'b0; m_ena = 1'b0; m_pend = 1'b0; m_rsp = '0; m_count = '0;
        end else if (m_total != 0) begin
            m_k++;
            if (m_k == m_total) begin
                m_total = 0;
                m_k = 0;
            end else if (m_k % (2 * HP) == 0) begin
                m_count++;
            end
        end else if (m_pend) begin
            if (rsp_ready) m_pend = 1'b0;
        end else if (cmd_valid) begin
            case (cmd_op)
                3'd0: m_ui = cmd_data;
                3'd1: m_uio = cmd_data;
                3'd2: begin
                    m_rstn = cmd_data[0];
                    m_ena = cmd_data[1];
                    if (!cmd_data[0]) m_count = '0;
                end
                3'd3: begin
                    m_total = 2 * HP * ((cmd_data == 8'd0) ? 256 : int'(cmd_data));
                    m_k = 0;
                    m_count++;
                end
                3'd4: begin m_rsp = ow; m_pend = 1'b1; end
                3'd5: begin m_rsp = CNT_EN ? m_count : 24'd0; m_pend = 1'b1; end
                default: ;
            endcase
        end
    end

    always @(posedge clk) begin
        logic m_pclk, m_ready;
        #1;
        m_pclk  = (m_total != 0) && (((m_k / HP) % 2) == 0);
        m_ready = (m_total == 0) && !m_pend;
        if (chk_on) begin
            chk("iw", iw, {m_uio, m_ui, m_rstn, m_pclk});
            chk("ena", ena, m_ena);
            chk("cmd_ready", cmd_ready, m_ready);
            chk("busy", busy, !m_ready);
            chk("rsp_valid", rsp_valid, m_pend);
            if (m_pend) chk("rsp_data", rsp_data, m_rsp);
        end
        if (iw[0] && !prev_clk) edges++;
        prev_clk = iw[0];
        if (busy) busy_cnt++;
    end

    always @(negedge clk) if (ow_rand) ow = $urandom;

    task automatic send_w(input logic [2:0] op, input logic [7:0] d, output int waits);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d; waits = 0;
        while (!cmd_ready && waits < 3000) begin
            @(negedge clk);
            waits++;
        end
        if (!cmd_ready) chk("cmd_accept_timeout", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] d);
        int w;
        send_w(op, d, w);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!cmd_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("idle_timeout", cmd_ready, 1);
    endtask

    task automatic get_rsp(input int hold, output logic [23:0] d);
        int n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) chk("rsp_timeout", rsp_valid, 1);
        for (int i = 0; i < hold; i++) @(negedge clk);
        d = rsp_data;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] d, v;
        int w, n;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
        rsp_ready = 1'b0; ow = '0;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        chk("reset_iw", iw, 18'h0);
        chk("reset_ena", ena, 0);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        rst = 1'b0;

        send(3'd0, 8'hA5);
        send(3'd1, 8'h3C);
        send(3'd2, 8'h03);
        chk("set_pins_iw", iw, 18'h0F296);
        chk("set_pins_ena", ena, 1);

        busy_cnt = 0; edges = 0;
        send(3'd3, 8'd3);
        send_w(3'd6, 8'h00, w);
        chk("blocked_cmd_waits", w, 12);
        wait_idle();
        chk("clock3_busy_cycles", busy_cnt, 12);
        chk("clock3_pulses", edges, 3);

        send(3'd2, 8'h02);
        send(3'd2, 8'h03);
        edges = 0;
        send(3'd3, 8'd0);
        wait_idle();
        chk("clock256_pulses", edges, 256);
        chk("clock256_iw0_low", iw[0], 0);
        send(3'd5, 8'h00);
        get_rsp(0, d);
        chk("get_count", d, CNT_EN ? 24'd256 : 24'd0);

        ow = 24'h123456;
        send(3'd4, 8'h00);
        for (int i = 0; i < 5; i++) begin
            chk("sample_hold_ready", cmd_ready, 0);
            ow = $urandom;
            @(negedge clk);
        end
        get_rsp(0, d);
        chk("sample_data", d, 24'h123456);

        send(3'd3, 8'd4);
        repeat (3) @(negedge clk);
        n = 0;
        while (!iw[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort_iw0_high", iw[0], 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_iw", iw, 18'h0);
        chk("abort_cmd_ready", cmd_ready, 1);
        chk("abort_busy", busy, 0);
        v = $urandom;
        ow = v;
        send(3'd4, 8'h00);
        get_rsp(2, d);
        chk("post_abort_sample", d, v);

        ow_rand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            logic [2:0] op;
            logic [7:0] dat;
            op  = 3'($urandom_range(0, 7));
            dat = 8'($urandom);
            if (op == 3'd3) dat = 8'($urandom_range(1, 5));
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(op, dat);
            if (op == 3'd4 || op == 3'd5) get_rsp($urandom_range(0, 3), d);
        end
        wait_idle();
        ow_rand = 1'b0;
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
